// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU); optional macro DIV_FASTPATH_EN
module div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
   localparam logic [CNT_W-1:0]      LAST_IT  = CNT_W'(DATA_WIDTH - 1);

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic                  is_rem_q;
   logic                  q_neg_q;
   logic                  r_neg_q;
   logic                  special_q;
   logic [DATA_WIDTH-1:0] special_res_q;
   logic [DATA_WIDTH-1:0] rem_q;
   logic [DATA_WIDTH-1:0] quo_q;
   logic [DATA_WIDTH-1:0] dvs_q;

   // request decode: operand magnitudes and the special cases
   logic                  accept;
   logic                  in_signed;
   logic                  a_neg;
   logic                  b_neg;
   logic [DATA_WIDTH-1:0] a_mag;
   logic [DATA_WIDTH-1:0] b_mag;
   logic                  in_div0;
   logic                  in_ovf;
   logic                  in_special;
   logic [DATA_WIDTH-1:0] in_spec_res;
   logic                  take_fast;

   // classify the incoming request and precompute substitute results
   always_comb begin
      accept      = start && ((state == S_IDLE) || (state == S_DONE));
      in_signed   = ~op[0];
      a_neg       = in_signed & dividend[DATA_WIDTH-1];
      b_neg       = in_signed & divisor[DATA_WIDTH-1];
      a_mag       = a_neg ? (~dividend + 1'b1) : dividend;
      b_mag       = b_neg ? (~divisor + 1'b1) : divisor;
      in_div0     = (divisor == '0);
      in_ovf      = in_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);
      in_special  = in_div0 || in_ovf;
      in_spec_res = '0;
      if (in_div0) begin
         in_spec_res = op[1] ? dividend : ALL_ONES;
      end else if (in_ovf) begin
         in_spec_res = op[1] ? '0 : dividend;
      end
`ifdef DIV_FASTPATH_EN
      // magnitude smaller than divisor: quotient 0, remainder is the raw dividend
      take_fast = in_special || (a_mag < b_mag);
      if (!in_special && (a_mag < b_mag)) begin
         in_spec_res = op[1] ? dividend : '0;
      end
`else
      take_fast = 1'b0;
`endif
   end

   // one restoring step plus sign fix-up of the would-be final values
   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH:0]   diff;
   logic                  ge;
   logic [DATA_WIDTH-1:0] step_rem;
   logic [DATA_WIDTH-1:0] step_quo;
   logic [DATA_WIDTH-1:0] final_q;
   logic [DATA_WIDTH-1:0] final_r;

   // restoring iteration: shift pair left, trial subtract, restore on negative
   always_comb begin
      shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
      diff     = shifted - {1'b0, dvs_q};
      ge       = (shifted >= {1'b0, dvs_q});
      step_rem = ge ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
      step_quo = {quo_q[DATA_WIDTH-2:0], ge};
      final_q  = q_neg_q ? (~step_quo + 1'b1) : step_quo;
      final_r  = r_neg_q ? (~step_rem + 1'b1) : step_rem;
   end

   // control FSM, iteration datapath and the registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         result        <= '0;
         is_rem_q      <= 1'b0;
         q_neg_q       <= 1'b0;
         r_neg_q       <= 1'b0;
         special_q     <= 1'b0;
         special_res_q <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         dvs_q         <= '0;
      end else begin
         case (state)
            S_CALC: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_IT) begin
                  state  <= S_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  cnt    <= '0;
                  if (special_q) begin
                     result <= special_res_q;
                  end else begin
                     result <= is_rem_q ? final_r : final_q;
                  end
               end
            end
            default: begin
               // IDLE and DONE both accept; DONE otherwise falls back to IDLE
               done <= 1'b0;
               if (accept) begin
                  is_rem_q      <= op[1];
                  q_neg_q       <= a_neg ^ b_neg;
                  r_neg_q       <= a_neg;
                  special_q     <= in_special;
                  special_res_q <= in_spec_res;
                  if (take_fast) begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     result <= in_spec_res;
                  end else begin
                     state <= S_CALC;
                     busy  <= 1'b1;
                     cnt   <= '0;
                     rem_q <= '0;
                     quo_q <= a_mag;
                     dvs_q <= b_mag;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider implementing RV32M DIV, DIVU, REM and REMU for the EX stage. Its registered result drives input 2 of the 3-way result/forwarding select mux, alongside the ALU result and the memory load data. Its busy output feeds the hazard unit, which stalls the front of the pipeline while a division is in flight.

## Interface
- DATA_WIDTH, 32, operand and result width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE or DONE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- dividend  input  DATA_WIDTH  rs1 value, sampled with an accepted start.
- divisor  input  DATA_WIDTH  rs2 value, sampled with an accepted start.
- busy  output  1  high while in CALC.
- done  output  1  single-cycle pulse; result valid.
- result  output  DATA_WIDTH  quotient or remainder per latched op; held until the next accepted start.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: DATA_WIDTH iterations, one quotient bit per cycle.
  - DONE: one cycle, done=1.
- Accept: start=1 in IDLE or DONE latches op, operands and sign info. Otherwise start is ignored, with no queuing.
- Signed ops (DIV, REM): divide the magnitudes. Negate the quotient if the operand signs differ. The remainder takes the dividend's sign.
- Unsigned ops: operands are used as-is.
- Each CALC cycle runs one restoring step: shift the {remainder, quotient} pair left by 1, trial-subtract the divisor (DATA_WIDTH+1-bit compare), restore on negative, then set the quotient LSB.
- Divide by zero:
  - Quotient = all ones (DIV and DIVU).
  - Remainder = dividend, unmodified.
- Signed overflow (dividend = 1 followed by zeros, divisor = all ones, op=DIV/REM):
  - Quotient = dividend.
  - Remainder = 0.
- result is written only on entry to DONE. It holds in IDLE and CALC until then.
- Transitions:
  - IDLE + start → CALC, or → DONE on the fast path.
  - CALC → DONE after DATA_WIDTH cycles.
  - DONE + start → CALC / DONE (back-to-back).
  - DONE without start → IDLE.
- Reset (any state, including mid-CALC): state=IDLE, busy=0, done=0, result=0, iteration counter=0. The in-flight operation is discarded.

## Timing
- Request accepted at rising edge k.
- Normal path:
  - busy=1 in cycles k+1 … k+DATA_WIDTH.
  - done=1 and result valid in cycle k+DATA_WIDTH+1.
- done is high for exactly one cycle per accepted start.
- busy and done are never high together.
- Back-to-back: a start during DONE at edge j gives busy=1 from j+1, and the next done at j+DATA_WIDTH+1.
- The iteration counter is $clog2(DATA_WIDTH)+1 bits and counts 0 … DATA_WIDTH-1.
- Outputs are registered; there is no combinational path from inputs to busy, done or result.

## Configuration
- DIV_FASTPATH_EN defined:
  - Divide-by-zero and signed overflow skip CALC; IDLE/DONE + start goes directly to DONE.
  - done=1 at cycle k+1 and busy stays 0.
  - Dividend < divisor (unsigned magnitude compare) also takes the fast path: quotient 0, remainder = dividend.
- Undefined:
  - Every operation takes the full DATA_WIDTH+1-cycle latency.
  - Special-case results are substituted at the CALC→DONE transition.
  - Result values are identical in both builds.

## Test plan
- DIVU 100/7, then REMU 100/7 → result 14, then 2. done at k+33, busy high for exactly 32 cycles.
- DIV -7/2 (0xFFFFFFF9 / 0x2) → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; REM 7/-2 → 0x00000001.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 0x00000005; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. Latency is 1 cycle with DIV_FASTPATH_EN and 33 cycles without.
- Assert rst at CALC iteration 10 → next cycle: busy=0, done=0, result=0. A following DIVU 9/3 → 3 with the normal latency.
- start held high through DONE with new operands (DIVU 50/5) → second done exactly 33 cycles after the first, result 10. start pulses during CALC are ignored and result is unchanged until DONE.
